wb_cmd_master: RTL and testbench

- Wishbone classic (B4, non-pipelined) initiator.
- Converts single-beat read/write commands, arriving on a valid/ready command channel, into Wishbone cycles; returns read data or an error on a valid/ready response channel.
- It is the initiator counterpart of the wrapper's Wishbone slave port and sits inside the user area.
- Use cases: driving the slave in loopback benches, or reaching user-side peripherals from an LA- or IO-driven sequencer.

---
 rtl/wb_master_pkg.sv | 19 +
 rtl/wb_timeout_ctr.sv | 42 ++++
 rtl/wb_cmd_master.sv | 146 ++++++++++++++
 tb/tb_wb_cmd_master.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone command master.
//   state_t     : master FSM states
//   AW_DEF/DW_DEF: default address/data widths
//   RSP_OK/RSP_TIMEOUT: values carried on rsp_err
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned AW_DEF = 32;
    localparam int unsigned DW_DEF = 32;

    localparam logic RSP_OK      = 1'b0;
    localparam logic RSP_TIMEOUT = 1'b1;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating bus-wait counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart count at zero
//   en         : count this cycle
//   expired_c  : high in the cycle whose edge makes the count reach TIMEOUT
// With TIMEOUT=0 no counter exists and expired_c is tied low.
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    if (TIMEOUT > 0) begin : g_ctr
        localparam int unsigned CW = $clog2(TIMEOUT + 1);

        logic [CW-1:0] cnt_q;

        // Counts enabled cycles, holding at TIMEOUT.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (clr) begin
                cnt_q <= '0;
            end else if (en && (cnt_q != CW'(TIMEOUT))) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end

        // Flag the cycle before the count lands on TIMEOUT so the caller
        // leaves after exactly TIMEOUT enabled cycles.
        assign expired_c = en && (cnt_q >= CW'(TIMEOUT - 1));
    end else begin : g_no_ctr
        logic unused_c;
        assign unused_c  = clk ^ rst_n ^ clr ^ en;
        assign expired_c = 1'b0;
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic (non-pipelined) initiator driven by a valid/ready
// command channel; returns read data or a timeout error on a valid/ready
// response channel. One transaction outstanding at a time.
//   wb_clk_i, wb_rst_ni                    : clock, async active-low reset
//   cmd_valid/ready, cmd_we/adr/dat/sel    : command channel
//   rsp_valid/ready, rsp_dat/err           : response channel
//   wbm_cyc/stb/we/sel/adr/dat_o, wbm_ack_i, wbm_dat_i : Wishbone master port
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic            wbm_ack_i,
    input  logic [DW-1:0]   wbm_dat_i
);

    localparam int unsigned SW = DW / 8;

    state_t          state_q, state_d;
    logic            cmd_ready_d, cyc_d, we_d, rsp_valid_d, rsp_err_d;
    logic [SW-1:0]   sel_d;
    logic [AW-1:0]   adr_d;
    logic [DW-1:0]   dat_d, rsp_dat_d;
    logic            accept_c, expired_c;

    assign accept_c  = (state_q == IDLE) && cmd_valid && cmd_ready;
    assign wbm_stb_o = wbm_cyc_o;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .clr       (accept_c),
        .en        (state_q == BUS),
        .expired_c (expired_c)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = 1'b0;
        cyc_d       = wbm_cyc_o;
        we_d        = wbm_we_o;
        sel_d       = wbm_sel_o;
        adr_d       = wbm_adr_o;
        dat_d       = wbm_dat_o;
        rsp_valid_d = rsp_valid;
        rsp_err_d   = rsp_err;
        rsp_dat_d   = rsp_dat;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept_c) begin
                    state_d     = BUS;
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    we_d        = cmd_we;
                    sel_d       = cmd_sel;
                    adr_d       = cmd_adr;
                    dat_d       = cmd_dat;
                end
            end
            BUS: begin
                // Ack takes priority over a simultaneous timeout.
                if (wbm_ack_i || expired_c) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = '0;
                    adr_d       = '0;
                    dat_d       = '0;
                    rsp_valid_d = 1'b1;
                    if (wbm_ack_i) begin
                        rsp_err_d = RSP_OK;
                        rsp_dat_d = wbm_we_o ? '0 : wbm_dat_i;
                    end else begin
                        rsp_err_d = RSP_TIMEOUT;
                        rsp_dat_d = '0;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus cycle immediately.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            cmd_ready <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dat   <= '0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= cmd_ready_d;
            wbm_cyc_o <= cyc_d;
            wbm_we_o  <= we_d;
            wbm_sel_o <= sel_d;
            wbm_adr_o <= adr_d;
            wbm_dat_o <= dat_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_dat   <= rsp_dat_d;
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master (TIMEOUT=4).
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;

    int checks = 0;
    int failures = 0;

    wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required finish", $time);
        $fatal(1, "watchdog");
    end

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 6'b0 ||
            rsp_dat !== 32'h0 || wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || wbm_sel_o !== 4'h0) begin
            failures++;
            $display("FAIL reset_outputs: cmd_ready=%b rsp_valid=%b cyc=%b adr=%h required all zero",
                     cmd_ready, rsp_valid, wbm_cyc_o, wbm_adr_o);
        end
        #21 rst_n = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: cmd_ready=%b cyc=%b required 1/0", cmd_ready, wbm_cyc_o);
        end
    endtask

    task automatic test_write();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0004;
        cmd_dat = 32'hDEAD_BEEF; cmd_sel = 4'hF; wbm_dat_i = 32'h5555_5555;
        tick();
        cmd_valid = 1'b0; wbm_ack_i = 1'b1;
        checks++;
        if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1 || cmd_ready !== 1'b0 ||
            wbm_adr_o !== 32'h3000_0004 || wbm_dat_o !== 32'hDEAD_BEEF || wbm_sel_o !== 4'hF) begin
            failures++;
            $display("FAIL write_bus: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h required 1 1 1 30000004 deadbeef f",
                     wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
        end
        tick();
        wbm_ack_i = 1'b0; wbm_dat_i = '0;
        checks++;
        if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0 ||
            wbm_adr_o !== 32'h0 || wbm_we_o !== 1'b0) begin
            failures++;
            $display("FAIL write_rsp: cyc=%b rsp_valid=%b err=%b dat=%h adr=%h required 0 1 0 0 0",
                     wbm_cyc_o, rsp_valid, rsp_err, rsp_dat, wbm_adr_o);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL write_done: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    // Ack in the 4th bus cycle also coincides with the timeout boundary.
    task automatic test_read_wait();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0010; cmd_sel = 4'hF; cmd_dat = 32'hFFFF_0000;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h3000_0010 || wbm_we_o !== 1'b0) begin
                failures++;
                $display("FAIL read_wait%0d: cyc=%b adr=%h we=%b required 1 30000010 0",
                         i, wbm_cyc_o, wbm_adr_o, wbm_we_o);
            end
            tick();
        end
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678;
        checks++;
        if (wbm_cyc_o !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_cycle4: cyc=%b rsp_valid=%b required 1 0", wbm_cyc_o, rsp_valid);
        end
        tick();
        wbm_ack_i = 1'b0; wbm_dat_i = '0;
        checks++;
        if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h1234_5678) begin
            failures++;
            $display("FAIL read_rsp: cyc=%b rsp_valid=%b err=%b dat=%h required 0 1 0 12345678",
                     wbm_cyc_o, rsp_valid, rsp_err, rsp_dat);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'h3;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wbm_cyc_o !== 1'b1) begin
                failures++;
                $display("FAIL timeout_bus%0d: cyc=%b required 1", i, wbm_cyc_o);
            end
            tick();
        end
        checks++;
        if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0) begin
            failures++;
            $display("FAIL timeout_rsp: cyc=%b rsp_valid=%b err=%b dat=%h required 0 1 1 0",
                     wbm_cyc_o, rsp_valid, rsp_err, rsp_dat);
        end
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hFFFF_FFFF;
        tick();
        wbm_ack_i = 1'b0; wbm_dat_i = '0;
        checks++;
        if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0) begin
            failures++;
            $display("FAIL timeout_late_ack: cyc=%b rsp_valid=%b err=%b dat=%h required 0 1 1 0",
                     wbm_cyc_o, rsp_valid, rsp_err, rsp_dat);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL timeout_done: rsp_valid=%b err=%b cmd_ready=%b required 0 0 1",
                     rsp_valid, rsp_err, cmd_ready);
        end
    endtask

    task automatic test_backpressure();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0030; cmd_sel = 4'hF;
        tick();
        cmd_valid = 1'b0; wbm_ack_i = 1'b1; wbm_dat_i = 32'hA5A5_0F0F;
        tick();
        wbm_ack_i = 1'b0; wbm_dat_i = '0;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0040; cmd_dat = 32'h0000_00AA; cmd_sel = 4'h1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_dat !== 32'hA5A5_0F0F || rsp_err !== 1'b0 ||
                cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: rsp_valid=%b dat=%h cmd_ready=%b cyc=%b required 1 a5a50f0f 0 0",
                         i, rsp_valid, rsp_dat, cmd_ready, wbm_cyc_o);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: rsp_valid=%b cmd_ready=%b cyc=%b required 0 1 0",
                     rsp_valid, cmd_ready, wbm_cyc_o);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h3000_0040 || wbm_sel_o !== 4'h1 || wbm_we_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_second_cmd: cyc=%b adr=%h sel=%h we=%b required 1 30000040 1 1",
                     wbm_cyc_o, wbm_adr_o, wbm_sel_o, wbm_we_o);
        end
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0050; cmd_dat = 32'h1111_2222; cmd_sel = 4'hF;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (wbm_cyc_o !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: cyc=%b required 1", wbm_cyc_o);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 ||
            wbm_adr_o !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_async: cyc=%b stb=%b rsp_valid=%b cmd_ready=%b adr=%h required all 0",
                     wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, wbm_adr_o);
        end
        #12 rst_n = 1'b1;
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_after%0d: cmd_ready=%b rsp_valid=%b cyc=%b required 1 0 0",
                         i, cmd_ready, rsp_valid, wbm_cyc_o);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  sels [3];
        logic [31:0] adrs [3];
        sels = '{4'h1, 4'h6, 4'h8};
        adrs = '{32'h3000_0100, 32'h3000_0104, 32'h3000_0108};
        rsp_ready = 1'b1; wbm_ack_i = 1'b1; cmd_we = 1'b1;
        cmd_valid = 1'b1; cmd_adr = adrs[0]; cmd_sel = sels[0]; cmd_dat = 32'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (wbm_cyc_o !== 1'b1 || wbm_sel_o !== sels[k] || wbm_adr_o !== adrs[k]) begin
                failures++;
                $display("FAIL b2b_bus%0d: cyc=%b sel=%h adr=%h required 1 %h %h",
                         k, wbm_cyc_o, wbm_sel_o, wbm_adr_o, sels[k], adrs[k]);
            end
            if (k < 2) begin
                cmd_adr = adrs[k+1]; cmd_sel = sels[k+1]; cmd_dat = 32'(k + 1);
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            checks++;
            if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
                failures++;
                $display("FAIL b2b_rsp%0d: cyc=%b rsp_valid=%b err=%b required 0 1 0",
                         k, wbm_cyc_o, rsp_valid, rsp_err);
            end
            tick();
            checks++;
            if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_idle%0d: cyc=%b rsp_valid=%b cmd_ready=%b required 0 0 1",
                         k, wbm_cyc_o, rsp_valid, cmd_ready);
            end
        end
        tick();
        checks++;
        if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_quiet: cyc=%b rsp_valid=%b required 0 0", wbm_cyc_o, rsp_valid);
        end
        rsp_ready = 1'b0; wbm_ack_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
